// File: rtl/maze_mem_arbiter.sv
// maze_mem_arbiter: shares the single-port maze cell memory between the game
// logic (single reads/writes) and the LED display scanner (fixed-length read
// bursts). Round-robin on contention; a burst runs to completion once granted.
// Memory read data returns one cycle after the address and is forwarded to the
// requester that issued it through a small state-independent valid pipe.
module maze_mem_arbiter #(
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 2,
    parameter int BURST_LEN = 8
) (
    input  logic              clk,
    input  logic              nst,
    input  logic              g_req,
    input  logic              g_we,
    input  logic [ADDR_W-1:0] g_addr,
    input  logic [DATA_W-1:0] g_wdata,
    output logic              g_gnt,
    output logic              g_rvalid,
    output logic [DATA_W-1:0] g_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GAME   = 2'd1,
        DBURST = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              rr_disp_last_q, rr_disp_last_d;
    logic [CNT_W-1:0]  beat_q, beat_d;
    logic [ADDR_W-1:0] base_q, base_d;

    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              g_gnt_q, g_gnt_d;
    logic              d_gnt_q, d_gnt_d;

    logic              g_vld_p1_q, g_vld_p1_d;
    logic              d_vld_p1_q, d_vld_p1_d;
    logic              d_last_p1_q, d_last_p1_d;

    logic              take_game;
    logic              take_disp;
    logic [CNT_W-1:0]  beat_next;

    // On a tie the requester that did not win last time takes the memory.
    assign take_game = g_req && (!d_req || rr_disp_last_q);
    assign take_disp = d_req && (!g_req || !rr_disp_last_q);
    assign beat_next = beat_q + CNT_W'(1);

    // Next state and next registered bus/grant values; bus idles at zero.
    always_comb begin
        state_d        = state_q;
        rr_disp_last_d = rr_disp_last_q;
        beat_d         = beat_q;
        base_d         = base_q;
        mem_addr_d     = '0;
        mem_we_d       = 1'b0;
        mem_wdata_d    = '0;
        g_gnt_d        = 1'b0;
        d_gnt_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (take_game) begin
                    state_d        = GAME;
                    rr_disp_last_d = 1'b0;
                    g_gnt_d        = 1'b1;
                    mem_addr_d     = g_addr;
                    mem_we_d       = g_we;
                    mem_wdata_d    = g_wdata;
                end else if (take_disp) begin
                    state_d        = DBURST;
                    rr_disp_last_d = 1'b1;
                    base_d         = d_addr;
                    beat_d         = '0;
                    d_gnt_d        = 1'b1;
                    mem_addr_d     = d_addr;
                end
            end
            // Single access cycle; always return to IDLE so a still-high
            // g_req is not mistaken for a fresh request.
            GAME: begin
                state_d = IDLE;
            end
            // Address wraps naturally through the ADDR_W-bit sum.
            DBURST: begin
                if (beat_q == LAST_BEAT) begin
                    state_d = IDLE;
                    beat_d  = '0;
                end else begin
                    beat_d     = beat_next;
                    mem_addr_d = base_q + ADDR_W'(beat_next);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read-return pipe: tracks the access presented this cycle, regardless of
    // what state the FSM moves to next.
    always_comb begin
        g_vld_p1_d  = (state_q == GAME) && !mem_we_q;
        d_vld_p1_d  = (state_q == DBURST);
        d_last_p1_d = (state_q == DBURST) && (beat_q == LAST_BEAT);
    end

    // FSM state, arbitration pointer and registered bus/grant outputs.
    always_ff @(posedge clk) begin
        if (nst) begin
            state_q        <= IDLE;
            rr_disp_last_q <= 1'b1;
            beat_q         <= '0;
            mem_addr_q     <= '0;
            mem_we_q       <= 1'b0;
            mem_wdata_q    <= '0;
            g_gnt_q        <= 1'b0;
            d_gnt_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_disp_last_q <= rr_disp_last_d;
            beat_q         <= beat_d;
            mem_addr_q     <= mem_addr_d;
            mem_we_q       <= mem_we_d;
            mem_wdata_q    <= mem_wdata_d;
            g_gnt_q        <= g_gnt_d;
            d_gnt_q        <= d_gnt_d;
        end
    end

    // Burst base address; only meaningful while a burst is running.
    always_ff @(posedge clk) begin
        base_q <= base_d;
    end

    // Read-return valid pipe; reset drops any in-flight beats.
    always_ff @(posedge clk) begin
        if (nst) begin
            g_vld_p1_q  <= 1'b0;
            d_vld_p1_q  <= 1'b0;
            d_last_p1_q <= 1'b0;
        end else begin
            g_vld_p1_q  <= g_vld_p1_d;
            d_vld_p1_q  <= d_vld_p1_d;
            d_last_p1_q <= d_last_p1_d;
        end
    end

    assign g_gnt     = g_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);

    // Read data is steered to the owner of the returning beat, else held at 0.
    assign g_rvalid  = g_vld_p1_q;
    assign g_rdata   = g_vld_p1_q ? mem_rdata : '0;
    assign d_rvalid  = d_vld_p1_q;
    assign d_rdata   = d_vld_p1_q ? mem_rdata : '0;
    assign d_done    = d_last_p1_q;

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Testbench for maze_mem_arbiter: a synchronous-read memory model behind the
// DUT, two request drivers, and a negedge monitor that checks bus activity and
// read returns against a scoreboard built from a reference copy of the memory.
module tb_maze_mem_arbiter;

    localparam int ADDR_W    = 6;
    localparam int DATA_W    = 2;
    localparam int BURST_LEN = 8;
    localparam int DEPTH     = 1 << ADDR_W;

    logic              clk;
    logic              nst;
    logic              g_req, g_we;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;
    logic              g_gnt, g_rvalid;
    logic [DATA_W-1:0] g_rdata;
    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic              d_gnt, d_rvalid, d_done;
    logic [DATA_W-1:0] d_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    maze_mem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .BURST_LEN(BURST_LEN)
    ) dut (
        .clk      (clk),
        .nst      (nst),
        .g_req    (g_req),
        .g_we     (g_we),
        .g_addr   (g_addr),
        .g_wdata  (g_wdata),
        .g_gnt    (g_gnt),
        .g_rvalid (g_rvalid),
        .g_rdata  (g_rdata),
        .d_req    (d_req),
        .d_addr   (d_addr),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .d_done   (d_done),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: synchronous write and one-cycle registered read.
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    // Reference contents, updated in the order game writes are granted.
    int ref_mem [DEPTH];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, want, $time);
        end
    endtask

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } gop_t;

    gop_t g_pend[$];      // game ops requested, not yet granted
    int   d_pend[$];      // burst bases requested, not yet granted
    int   g_exp[$];       // expected game read data
    int   d_exp_data[$];  // expected burst beat data
    bit   d_exp_last[$];  // expected d_done per beat

    // Input values as seen by the DUT at the latest rising edge.
    logic nst_e, greq_e, dreq_e;
    always @(posedge clk) begin
        nst_e  <= nst;
        greq_e <= g_req;
        dreq_e <= d_req;
    end

    bit idle_prev  = 1'b0;
    bit last_game  = 1'b0;
    int beats_left = 0;
    int beat_k     = 0;
    int base       = 0;

    // Monitor: decides expected grants from the request/idle history, checks
    // the bus for each granted access, and retires read returns in order.
    always @(negedge clk) begin : monitor
        gop_t op;
        bit   exp_g, exp_d, in_burst, lst;
        int   v, a;
        if (nst_e) begin
            chk("reset_outputs", 32'({g_gnt, g_rvalid, g_rdata, d_gnt, d_rvalid, d_rdata,
                                      d_done, mem_addr, mem_we, mem_wdata, busy}), 32'd0);
            g_exp.delete();
            d_exp_data.delete();
            d_exp_last.delete();
            beats_left = 0;
            last_game  = 1'b0;
        end else begin
            if (g_rvalid) begin
                if (g_exp.size() == 0) chk("g_rvalid_unexpected", 32'(g_rvalid), 32'd0);
                else begin
                    v = g_exp.pop_front();
                    chk("g_rdata", 32'(g_rdata), 32'(v));
                end
            end
            if (d_rvalid) begin
                if (d_exp_data.size() == 0) chk("d_rvalid_unexpected", 32'(d_rvalid), 32'd0);
                else begin
                    v   = d_exp_data.pop_front();
                    lst = d_exp_last.pop_front();
                    chk("d_rdata", 32'(d_rdata), 32'(v));
                    chk("d_done", 32'(d_done), 32'(lst));
                end
            end else begin
                chk("d_done_without_rvalid", 32'(d_done), 32'd0);
            end

            exp_g = 1'b0;
            exp_d = 1'b0;
            if (idle_prev) begin
                if (greq_e && dreq_e) begin
                    exp_g = !last_game;
                    exp_d = last_game;
                end else begin
                    exp_g = greq_e;
                    exp_d = dreq_e;
                end
            end
            chk("grant", 32'({g_gnt, d_gnt}), 32'({exp_g, exp_d}));

            if (g_gnt) begin
                last_game = 1'b1;
                if (g_pend.size() == 0) chk("g_gnt_unexpected", 32'(g_gnt), 32'd0);
                else begin
                    op = g_pend.pop_front();
                    chk("g_mem_addr", 32'(mem_addr), 32'(op.addr));
                    chk("g_mem_we", 32'(mem_we), 32'(op.we));
                    if (op.we) begin
                        chk("g_mem_wdata", 32'(mem_wdata), 32'(op.wdata));
                        ref_mem[op.addr] = int'(op.wdata);
                    end else begin
                        g_exp.push_back(ref_mem[op.addr]);
                    end
                end
            end
            if (d_gnt) begin
                last_game = 1'b0;
                if (d_pend.size() == 0) chk("d_gnt_unexpected", 32'(d_gnt), 32'd0);
                else base = d_pend.pop_front();
                beats_left = BURST_LEN;
                beat_k     = 0;
            end

            in_burst = (beats_left > 0);
            chk("busy", 32'(busy), 32'(g_gnt || in_burst));
            if (in_burst) begin
                a = (base + beat_k) % DEPTH;
                chk("d_beat_addr", 32'(mem_addr), 32'(a));
                chk("d_no_write", 32'(mem_we), 32'd0);
                d_exp_data.push_back(ref_mem[a]);
                d_exp_last.push_back(beat_k == BURST_LEN - 1);
                beat_k++;
                beats_left--;
            end else if (!g_gnt) begin
                chk("idle_bus", 32'({mem_addr, mem_we, mem_wdata}), 32'd0);
            end
        end
        idle_prev = !busy;
    end

    task automatic game_op(input bit we, input int addr, input int wdata);
        gop_t op;
        int   n;
        op.we    = we;
        op.addr  = ADDR_W'(addr);
        op.wdata = DATA_W'(wdata);
        g_pend.push_back(op);
        g_we    = op.we;
        g_addr  = op.addr;
        g_wdata = op.wdata;
        g_req   = 1'b1;
        n = 0;
        @(negedge clk);
        while (!g_gnt && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("g_gnt_wait", 32'(g_gnt), 32'd1);
        @(posedge clk);
        #1;
        g_req = 1'b0;
    endtask

    task automatic disp_burst(input int addr);
        int n;
        d_pend.push_back(addr);
        d_addr = ADDR_W'(addr);
        d_req  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!d_gnt && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("d_gnt_wait", 32'(d_gnt), 32'd1);
        @(posedge clk);
        #1;
        d_req = 1'b0;
    endtask

    task automatic settle(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin : main
        int v, n, gap;
        for (int i = 0; i < DEPTH; i++) begin
            v = int'($urandom_range(0, 3));
            mem[i]     = DATA_W'(v);
            ref_mem[i] = v;
        end
        nst = 1'b1; g_req = 1'b0; g_we = 1'b0; g_addr = '0; g_wdata = '0;
        d_req = 1'b0; d_addr = '0;
        settle(3);
        nst = 1'b0;
        settle(2);

        // Directed single accesses and read-back of written cells.
        game_op(1, 5, 2);
        game_op(0, 5, 0);
        game_op(1, 9, 3);
        game_op(0, 9, 0);
        // Directed bursts: plain and wrapping past the top cell.
        disp_burst(0);
        settle(12);
        disp_burst(60);
        settle(12);

        // Both requesters held continuously.
        fork
            for (int i = 0; i < 4; i++) game_op(i % 2, 10 + i, i);
            for (int i = 0; i < 4; i++) disp_burst(8 * i + 3);
        join
        settle(12);

        // Game request raised mid-burst waits for the burst to finish.
        fork
            disp_burst(20);
            begin
                n = 0;
                @(negedge clk);
                while (!d_gnt && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                settle(2);
                game_op(0, 20, 0);
            end
        join
        settle(12);

        // Randomized traffic from both sides.
        fork
            for (int i = 0; i < 60; i++) begin
                gap = int'($urandom_range(0, 4));
                if (gap > 0) settle(gap);
                game_op(bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                        int'($urandom_range(0, 3)));
            end
            for (int i = 0; i < 20; i++) begin
                gap = int'($urandom_range(0, 10));
                if (gap > 0) settle(gap);
                disp_burst(int'($urandom_range(0, DEPTH - 1)));
            end
        join
        settle(12);

        // Reset during beat 4 of a burst abandons the remaining beats.
        disp_burst(40);
        settle(3);
        nst = 1'b1;
        settle(1);
        nst = 1'b0;
        settle(15);

        // Contention straight after reset: game must win the first tie.
        fork
            for (int i = 0; i < 3; i++) game_op(0, 30 + i, 0);
            for (int i = 0; i < 3; i++) disp_burst(61 - i);
        join
        settle(12);

        chk("g_read_queue_drained", 32'(g_exp.size()), 32'd0);
        chk("d_beat_queue_drained", 32'(d_exp_data.size()), 32'd0);
        chk("g_pending_drained", 32'(g_pend.size()), 32'd0);
        chk("d_pending_drained", 32'(d_pend.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
